// File: rtl/uart_rx_if.sv
// Host-side signal bundle for the UART receive core.
// master = register/host side, slave = uart_rx.
interface uart_rx_if #(
    parameter int DATA_SIZE = 8
);
    logic                 rx_start_n;
    logic                 serial_data_in;
    logic [DATA_SIZE-1:0] data_out;
    logic                 rx_done;
    logic                 parity_error;
    logic                 stop_error;
    logic                 break_error;
    logic                 overflow_error;

    modport master (
        output rx_start_n, serial_data_in,
        input  data_out, rx_done, parity_error, stop_error, break_error, overflow_error
    );

    modport slave (
        input  rx_start_n, serial_data_in,
        output data_out, rx_done, parity_error, stop_error, break_error, overflow_error
    );
endinterface

// File: rtl/uart_rx.sv
// UART receive core, 16x oversample clock, mid-bit sampling, sticky status flags.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx #(
    parameter int DATA_SIZE      = 8,
    parameter int BIT_COUNT_SIZE = $clog2(DATA_SIZE + 1)
) (
    input  logic      clk,
    input  logic      reset,
    uart_rx_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, DONE
    } state_t;

    state_t                    state;
    logic [3:0]                tick;
    logic [BIT_COUNT_SIZE-1:0] bit_cnt;
    logic [DATA_SIZE-1:0]      shift;
    logic                      stop_bit;
    logic                      sync1, sync2, sync_prev;
    logic [DATA_SIZE-1:0]      data_q;
    logic                      done_q, perr_q, serr_q, berr_q, ovf_q;
    logic                      line_fall;
    logic                      frame_perr, frame_berr;

    // Two-flop synchroniser plus one history flop for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync1     <= bus.serial_data_in;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    assign line_fall = sync_prev & ~sync2;

`ifdef UART_RX_PARITY_EN
    logic par_bit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            par_bit <= 1'b0;
        else if (state == PARITY && tick == 4'd7)
            par_bit <= sync2;
    end

    assign frame_perr = par_bit ^ (^shift);
    assign frame_berr = (shift == '0) && !par_bit && !stop_bit;
`else
    assign frame_perr = 1'b0;
    assign frame_berr = (shift == '0) && !stop_bit;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tick     <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            stop_bit <= 1'b0;
            data_q   <= '0;
            done_q   <= 1'b0;
            perr_q   <= 1'b0;
            serr_q   <= 1'b0;
            berr_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (bus.rx_start_n) begin
            // Receiver disabled: drop status and any frame in flight, keep data.
            state   <= IDLE;
            tick    <= '0;
            bit_cnt <= '0;
            done_q  <= 1'b0;
            perr_q  <= 1'b0;
            serr_q  <= 1'b0;
            berr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            tick <= tick + 4'd1;
            case (state)
                IDLE: begin
                    tick    <= '0;
                    bit_cnt <= '0;
                    if (line_fall)
                        state <= START;
                end
                // The free-running tick keeps wrapping, so every later
                // sample also lands on tick 7, 16 clocks apart.
                START: begin
                    if (tick == 4'd7)
                        state <= sync2 ? IDLE : DATA;
                end
                DATA: begin
                    if (tick == 4'd7) begin
                        shift   <= {sync2, shift[DATA_SIZE-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_COUNT_SIZE'(DATA_SIZE - 1))
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                    end
                end
                PARITY: begin
                    if (tick == 4'd7)
                        state <= STOP;
                end
                STOP: begin
                    if (tick == 4'd7) begin
                        stop_bit <= sync2;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (!done_q) begin
                        data_q <= shift;
                        done_q <= 1'b1;
                        perr_q <= frame_perr;
                        serr_q <= !stop_bit;
                        berr_q <= frame_berr;
                    end else begin
                        ovf_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data_out       = data_q;
    assign bus.rx_done        = done_q;
    assign bus.parity_error   = perr_q;
    assign bus.stop_error     = serr_q;
    assign bus.break_error    = berr_q;
    assign bus.overflow_error = ovf_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx; expected status comes from a
// frame-level model (what was sent on the line), not from the RTL structure.
module tb_uart_rx;
`ifdef UART_RX_PARITY_EN
    localparam bit HAS_PAR = 1'b1;
`else
    localparam bit HAS_PAR = 1'b0;
`endif
    localparam int BITC = 16;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] m_data;
    bit         m_done, m_perr, m_serr, m_berr, m_ovf;

    always #5 clk = ~clk;

    uart_rx_if #(.DATA_SIZE(8)) bus ();

    uart_rx #(.DATA_SIZE(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " data_out"},       32'(bus.data_out),       32'(m_data));
        chk({tag, " rx_done"},        32'(bus.rx_done),        32'(m_done));
        chk({tag, " parity_error"},   32'(bus.parity_error),   32'(m_perr));
        chk({tag, " stop_error"},     32'(bus.stop_error),     32'(m_serr));
        chk({tag, " break_error"},    32'(bus.break_error),    32'(m_berr));
        chk({tag, " overflow_error"}, 32'(bus.overflow_error), 32'(m_ovf));
    endtask

    task automatic model_clear();
        m_done = 0; m_perr = 0; m_serr = 0; m_berr = 0; m_ovf = 0;
    endtask

    // What the host should see once a frame has fully arrived.
    task automatic model_frame(input logic [7:0] d, input bit pbit, input bit sbit);
        if (m_done) begin
            m_ovf = 1;
        end else begin
            m_data = d;
            m_done = 1;
            m_perr = HAS_PAR && (pbit != ^d);
            m_serr = !sbit;
            m_berr = (d == 8'h00) && !sbit && (!HAS_PAR || !pbit);
        end
    endtask

    task automatic line(input logic v, input int n);
        bus.serial_data_in = v;
        repeat (n) @(negedge clk);
    endtask

    // Idle high for one bit, then the full frame; the line is left at the stop value.
    task automatic send_frame(input logic [7:0] d, input bit pbit, input bit sbit);
        line(1'b1, BITC);
        line(1'b0, BITC);
        for (int i = 0; i < 8; i++) line(d[i], BITC);
        if (HAS_PAR) line(pbit, BITC);
        line(sbit, BITC);
        model_frame(d, pbit, sbit);
    endtask

    task automatic pulse_enable();
        bus.rx_start_n = 1'b1;
        @(negedge clk);
        bus.rx_start_n = 1'b0;
        model_clear();
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] d;
        bit         pb, sb;

        reset              = 1'b1;
        bus.rx_start_n     = 1'b1;
        bus.serial_data_in = 1'b1;
        m_data = '0;
        model_clear();
        repeat (3) @(negedge clk);
        check_all("reset");
        reset          = 1'b0;
        bus.rx_start_n = 1'b0;
        line(1'b1, 2 * BITC);

        // Good frame 0xD5 (five ones -> even parity bit 1).
        send_frame(8'hD5, 1'b1, 1'b1);
        check_all("d5_good");

        // Same word, wrong parity.
        pulse_enable();
        check_all("clear1");
        send_frame(8'hD5, 1'b0, 1'b1);
        check_all("d5_badpar");

        // 0x3C with a low stop bit, then the line stays low: no retrigger.
        pulse_enable();
        send_frame(8'h3C, 1'b0, 1'b0);
        check_all("3c_stop0");
        line(1'b0, 12 * BITC);
        check_all("held_low");

        // Clear, then an all-zero frame held low: break.
        pulse_enable();
        line(1'b1, BITC);
        line(1'b0, 12 * BITC);
        model_frame(8'h00, 1'b0, 1'b0);
        check_all("break");
        line(1'b1, 2 * BITC);

        // False start: 4 clocks low, then high.
        pulse_enable();
        line(1'b0, 4);
        line(1'b1, 3 * BITC);
        check_all("false_start");
        send_frame(8'h81, 1'b0, 1'b1);
        check_all("after_false");

        // Overflow: second frame lost while rx_done is still set.
        pulse_enable();
        send_frame(8'hA5, 1'b0, 1'b1);
        send_frame(8'h5A, 1'b0, 1'b1);
        check_all("overflow");
        pulse_enable();
        check_all("ovf_clear");

        // Randomized frames with occasional bad parity, bad stop and clears.
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 1) == 0) pulse_enable();
            d  = 8'($urandom);
            if ($urandom_range(0, 5) == 0) d = 8'h00;
            pb = (^d) ^ ($urandom_range(0, 3) == 0);
            sb = ($urandom_range(0, 3) != 0);
            send_frame(d, pb, sb);
            check_all("random");
        end

        // Reset in the middle of data bit 4, then a clean 0x81.
        pulse_enable();
        send_frame(8'h3C, 1'b0, 1'b1);
        line(1'b1, BITC);
        line(1'b0, BITC);
        for (int i = 0; i < 4; i++) line(1'(8'h81 >> i), BITC);
        line(1'b0, BITC / 2);
        reset = 1'b1;
        #1;
        m_data = '0;
        model_clear();
        check_all("async_reset");
        bus.serial_data_in = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        send_frame(8'h81, 1'b0, 1'b1);
        check_all("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
